if_fetch_ctrl: RTL and testbench
================================

Name: if_fetch_ctrl

Overview:
- Fetch-side responder for the PC generator's pc_to_ic_bus: {excepttype[64:33], ce[32], pc[31:0]}.
- Each enabled PC becomes one request on an SRAM-like instruction port (req/addr_ok/data_ok handshake).
- Returned instructions are held for the decode stage on ic_to_id_bus.
- Raises stallreq to the stall controller while a fetch is in flight, and discards responses orphaned by a flush.

Parameters:
- EXC_ADEL_BIT, 4, bit of excepttype set on a misaligned fetch address.
- RESET_INST, 32'h0000_0000, instruction value driven while output is invalid (NOP).

Ports:
- clk  in  1  single clock; all logic on posedge.
- resetn  in  1  synchronous reset, active-low.
- pc_to_ic_bus  in  65  {excepttype[64:33], ce[32], pc[31:0]} from PC generator.
- flush  in  1  pipeline flush (exception/ERET); highest priority.
- stall_id  in  1  decode stage cannot accept this cycle.
- inst_req  out  1  request valid to instruction memory.
- inst_addr  out  32  request address.
- inst_addr_ok  in  1  request accepted this cycle.
- inst_data_ok  in  1  read data valid this cycle.
- inst_rdata  in  32  read data.
- ic_to_id_bus  out  97  {excepttype[96:65], valid[64], pc[63:32], inst[31:0]}.
- stallreq_ic  out  1  hold PC/front end; fetch not complete.

Behaviour:
- Reset (resetn=0 at posedge): state IDLE; inst_req=0; inst_addr=0; ic_to_id_bus all zero except inst=RESET_INST; stallreq_ic=0.
  - Reset mid-transaction drops all tracking. Memory is reset by the same resetn, so no stale data_ok is expected.
- Compact FSM states: IDLE, REQ, WAIT, CANCEL, DONE.
- IDLE:
  - ce=1 and flush=0: latch pc/excepttype into pc_r/exc_r.
    - If pc[1:0]==0, go to REQ.
    - Otherwise set exc_r[EXC_ADEL_BIT]=1, inst_r=RESET_INST, go to DONE without any memory request.
  - ce=0 or flush=1: stay IDLE.
- REQ:
  - inst_req=1 and inst_addr=pc_r, both registered and stable until inst_addr_ok.
  - addr_ok=1: go to WAIT, or to CANCEL if flush is also 1 that cycle.
  - flush=1 with addr_ok=0: inst_req drops next cycle; go to IDLE.
- WAIT:
  - inst_req=0.
  - data_ok=1 and flush=0: inst_r<=inst_rdata; go to DONE.
  - data_ok=1 and flush=1: drop the data; go to IDLE.
  - flush=1 with data_ok=0: go to CANCEL.
- CANCEL: inst_req=0. On data_ok, discard the data and go to IDLE. Flush while in CANCEL has no effect.
- DONE:
  - valid=1; ic_to_id_bus={exc_r, 1, pc_r, inst_r}.
  - stall_id=0 and flush=0: handoff occurs this cycle; go to IDLE.
  - stall_id=1: all outputs held bit-stable.
  - flush=1: go to IDLE; valid=0 next cycle.
- valid=0 in every state except DONE. When valid=0, the pc/excepttype fields hold their last values and inst=RESET_INST.
- stallreq_ic:
  - 1 in REQ, WAIT and CANCEL.
  - 1 in IDLE when ce=1 and flush=0.
  - 0 in DONE; the PC advances at the handoff edge.
- At most one outstanding request. No new inst_req while in WAIT or CANCEL.
- Minimum latency with addr_ok asserted on the first req cycle and data_ok on the following cycle: 4 cycles from ce sampled in IDLE to valid output (IDLE, REQ, WAIT, DONE).
- Incoming excepttype bits pass through unchanged and are OR'd with the ADEL bit when applicable.

Test Plan:
1. Reset release, pc=0xBFC0_0000, ce=1; addr_ok on the first REQ cycle; data_ok two cycles later with 0x3C08_BFC0 -> inst_addr=0xBFC0_0000 held until addr_ok; ic_to_id_bus valid=1, pc=0xBFC0_0000, inst=0x3C08_BFC0, exc=0; stallreq_ic=0 in DONE.
2. Zero-wait memory, sequential PCs 0xBFC0_0000/04/08 -> three valid handoffs with correct pc/inst pairing; exactly one inst_req per PC; no duplicate or skipped address.
3. Flush in WAIT, then data_ok=0xDEAD_BEEF, then new PC 0xBFC0_0380 -> 0xDEAD_BEEF never appears with valid=1; next valid output has pc=0xBFC0_0380.
4. DONE with stall_id=1 for 3 cycles -> ic_to_id_bus bit-stable; inst_req=0; handoff on the first cycle with stall_id=0.
5. pc=0xBFC0_0002, ce=1 -> inst_req never asserted; valid=1, exc bit 4 set, inst=0x0000_0000.
6. resetn=0 during WAIT, and separately flush coincident with addr_ok in REQ -> reset: all outputs zero next cycle. Flush case: CANCEL absorbs the following data_ok and FSM returns to IDLE.

Source files
------------

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch responder: turns each enabled PC into one SRAM-like request,
// holds the returned instruction for decode and squashes responses orphaned by a flush.
module if_fetch_ctrl #(
   parameter int          EXC_ADEL_BIT = 4,
   parameter logic [31:0] RESET_INST   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [64:0] pc_to_ic_bus,
   input  logic        flush,
   input  logic        stall_id,
   output logic        inst_req,
   output logic [31:0] inst_addr,
   input  logic        inst_addr_ok,
   input  logic        inst_data_ok,
   input  logic [31:0] inst_rdata,
   output logic [96:0] ic_to_id_bus,
   output logic        stallreq_ic,
   output logic [2:0]  o_dbg_state
);

   // Handshake: inst_req/inst_addr stay asserted and stable until the cycle
   // inst_addr_ok is high; inst_data_ok returns exactly one word per accepted request.
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_REQ    = 3'd1,
      S_WAIT   = 3'd2,
      S_CANCEL = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   localparam logic [31:0] ADEL_MASK = 32'h1 << EXC_ADEL_BIT;

   state_t      r_state;
   logic        r_req;
   logic [31:0] r_addr;
   logic [31:0] r_pc;
   logic [31:0] r_exc;
   logic [31:0] r_inst;
   logic        r_valid;
   logic [31:0] r_out_pc;
   logic [31:0] r_out_exc;

   logic [31:0] w_exc;
   logic        w_ce;
   logic [31:0] w_pc;

   assign w_exc = pc_to_ic_bus[64:33];
   assign w_ce  = pc_to_ic_bus[32];
   assign w_pc  = pc_to_ic_bus[31:0];

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state   <= S_IDLE;
         r_req     <= 1'b0;
         r_addr    <= 32'h0;
         r_pc      <= 32'h0;
         r_exc     <= 32'h0;
         r_inst    <= RESET_INST;
         r_valid   <= 1'b0;
         r_out_pc  <= 32'h0;
         r_out_exc <= 32'h0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_ce && !flush) begin
                  r_pc <= w_pc;
                  if (w_pc[1:0] == 2'b00) begin
                     r_exc   <= w_exc;
                     r_req   <= 1'b1;
                     r_addr  <= w_pc;
                     r_state <= S_REQ;
                  end else begin
                     // Misaligned PC: report AdEL straight to decode, no memory access.
                     r_exc     <= w_exc | ADEL_MASK;
                     r_inst    <= RESET_INST;
                     r_valid   <= 1'b1;
                     r_out_pc  <= w_pc;
                     r_out_exc <= w_exc | ADEL_MASK;
                     r_state   <= S_DONE;
                  end
               end
            end
            S_REQ: begin
               if (inst_addr_ok) begin
                  r_req   <= 1'b0;
                  r_state <= flush ? S_CANCEL : S_WAIT;
               end else if (flush) begin
                  r_req   <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            S_WAIT: begin
               if (inst_data_ok) begin
                  if (flush) begin
                     r_state <= S_IDLE;
                  end else begin
                     r_inst    <= inst_rdata;
                     r_valid   <= 1'b1;
                     r_out_pc  <= r_pc;
                     r_out_exc <= r_exc;
                     r_state   <= S_DONE;
                  end
               end else if (flush) begin
                  r_state <= S_CANCEL;
               end
            end
            // The accepted request still owes one data_ok; swallow it.
            S_CANCEL: begin
               if (inst_data_ok) begin
                  r_state <= S_IDLE;
               end
            end
            S_DONE: begin
               if (flush || !stall_id) begin
                  r_valid <= 1'b0;
                  r_inst  <= RESET_INST;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign inst_req     = r_req;
   assign inst_addr    = r_addr;
   assign ic_to_id_bus = {r_out_exc, r_valid, r_out_pc, r_inst};
   assign o_dbg_state  = r_state;

   // Front end must hold while a fetch is pending or about to start.
   assign stallreq_ic = resetn &&
                        ((r_state == S_REQ) || (r_state == S_WAIT) || (r_state == S_CANCEL) ||
                         ((r_state == S_IDLE) && w_ce && !flush));

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl: scoreboard of expected decode handoffs and
// expected memory request addresses, checked by a negedge monitor.
module tb_if_fetch_ctrl;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CANCEL = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  logic        clk = 1'b0;
  logic        resetn;
  logic [64:0] pc_to_ic_bus;
  logic        flush;
  logic        stall_id;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic [96:0] ic_to_id_bus;
  logic        stallreq_ic;
  logic [2:0]  dbg_state;

  logic [96:0] exp_q[$];
  logic [31:0] exp_addr_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  if_fetch_ctrl #(.EXC_ADEL_BIT(4), .RESET_INST(32'h0000_0000)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .pc_to_ic_bus (pc_to_ic_bus),
    .flush        (flush),
    .stall_id     (stall_id),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .ic_to_id_bus (ic_to_id_bus),
    .stallreq_ic  (stallreq_ic),
    .o_dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [96:0] act, input logic [96:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s act=%h exp=%h", name, act, exp);
  endtask

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic leave_idle();
    int k;
    k = 0;
    do begin
      cyc();
      k++;
    end while (dbg_state == ST_IDLE && k < 20);
    if (dbg_state == ST_IDLE) begin
      n_checks++;
      $display("FAIL leave_idle act=stuck_idle exp=left_idle");
    end
  endtask

  task automatic start_pc(input logic [31:0] pc, input logic [31:0] exc);
    pc_to_ic_bus = {exc, 1'b1, pc};
    #1;
    check("stallreq_idle_ce", 97'(stallreq_ic), 97'd1);
    leave_idle();
    pc_to_ic_bus = {exc, 1'b0, pc};
  endtask

  // Full fetch: aw cycles before addr_ok, dw WAIT cycles before data_ok, stall_n DONE stall cycles.
  task automatic fetch(input logic [31:0] pc, input logic [31:0] exc, input int aw,
                       input int dw, input logic [31:0] rd, input int stall_n);
    logic [96:0] exp_bus;
    exp_bus = {exc, 1'b1, pc, rd};
    exp_q.push_back(exp_bus);
    exp_addr_q.push_back(pc);
    start_pc(pc, exc);
    for (int i = 0; i < aw; i++) begin
      check("req_hold", {inst_req, inst_addr}, {1'b1, pc});
      cyc();
    end
    check("req_addr", {inst_req, inst_addr}, {1'b1, pc});
    inst_addr_ok = 1'b1;
    cyc();
    inst_addr_ok = 1'b0;
    for (int i = 0; i < dw; i++) begin
      check("wait_no_req", {inst_req, stallreq_ic}, 2'b01);
      cyc();
    end
    inst_data_ok = 1'b1;
    inst_rdata   = rd;
    stall_id     = (stall_n > 0);
    cyc();
    inst_data_ok = 1'b0;
    inst_rdata   = $urandom;
    check("done_stallreq", 97'(stallreq_ic), 97'd0);
    for (int i = 0; i < stall_n; i++) begin
      check("stall_bus_hold", ic_to_id_bus, exp_bus);
      check("stall_no_req", 97'(inst_req), 97'd0);
      cyc();
    end
    stall_id = 1'b0;
    cyc();
    check("handoff_idle", 97'(dbg_state), 97'(ST_IDLE));
  endtask

  // scoreboard monitor
  initial begin
    forever begin
      @(negedge clk);
      if (resetn) begin
        if (inst_req && inst_addr_ok) begin
          if (exp_addr_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_req act=%h exp=none", inst_addr);
          end else begin
            check("req_accept_addr", 97'(inst_addr), 97'(exp_addr_q.pop_front()));
          end
        end
        if (ic_to_id_bus[64] && !stall_id && !flush) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_valid act=%h exp=none", ic_to_id_bus);
          end else begin
            check("handoff_bus", ic_to_id_bus, exp_q.pop_front());
          end
        end
      end
    end
  end

  // directed stimulus
  initial begin
    resetn       = 1'b0;
    pc_to_ic_bus = '0;
    flush        = 1'b0;
    stall_id     = 1'b0;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    inst_rdata   = 32'h0;
    repeat (3) cyc();
    check("reset_bus", ic_to_id_bus, 97'h0);
    check("reset_req", {65'h0, inst_req, inst_addr}, 97'h0);
    check("reset_stallreq", 97'(stallreq_ic), 97'd0);
    resetn = 1'b1;
    cyc();

    // 1: first fetch, data_ok two cycles after addr_ok
    fetch(32'hBFC0_0000, 32'h0, 0, 1, 32'h3C08_BFC0, 0);

    // 2: zero-wait sequential PCs
    fetch(32'hBFC0_0000, 32'h0, 0, 0, 32'h1111_0000, 0);
    fetch(32'hBFC0_0004, 32'h0, 0, 0, 32'h2222_0004, 0);
    fetch(32'hBFC0_0008, 32'h0, 2, 0, 32'h3333_0008, 0);

    // 3: flush in WAIT, orphaned data, then new PC
    exp_addr_q.push_back(32'hBFC0_0010);
    start_pc(32'hBFC0_0010, 32'h0);
    inst_addr_ok = 1'b1;
    cyc();
    inst_addr_ok = 1'b0;
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    check("flush_wait_cancel", 97'(dbg_state), 97'(ST_CANCEL));
    cyc();
    inst_data_ok = 1'b1;
    inst_rdata   = 32'hDEAD_BEEF;
    cyc();
    inst_data_ok = 1'b0;
    check("cancel_to_idle", {94'h0, dbg_state}, {94'h0, ST_IDLE});
    check("cancel_no_valid", 97'(ic_to_id_bus[64]), 97'd0);
    fetch(32'hBFC0_0380, 32'h0, 0, 0, 32'h4000_0380, 0);

    // flush coincident with data_ok in WAIT
    exp_addr_q.push_back(32'hBFC0_0014);
    start_pc(32'hBFC0_0014, 32'h0);
    inst_addr_ok = 1'b1;
    cyc();
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b1;
    inst_rdata   = 32'hDEAD_BEEF;
    flush        = 1'b1;
    cyc();
    inst_data_ok = 1'b0;
    flush        = 1'b0;
    check("wait_flush_data_idle", 97'(dbg_state), 97'(ST_IDLE));

    // flush in REQ without addr_ok
    start_pc(32'hBFC0_0018, 32'h0);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    check("req_flush_drop", {inst_req, dbg_state}, {1'b0, ST_IDLE});

    // 4: DONE stalled for 3 cycles, exception bits pass through
    fetch(32'hBFC0_0100, 32'h8000_0000, 0, 0, 32'h2408_0001, 3);

    // 5: misaligned PC -> AdEL, no memory request
    exp_q.push_back({32'h0000_0110, 1'b1, 32'hBFC0_0002, 32'h0});
    start_pc(32'hBFC0_0002, 32'h0000_0100);
    check("adel_done", {inst_req, stallreq_ic, dbg_state}, {1'b0, 1'b0, ST_DONE});
    cyc();

    // flush in DONE drops the output
    exp_addr_q.push_back(32'hBFC0_0020);
    start_pc(32'hBFC0_0020, 32'h0);
    inst_addr_ok = 1'b1;
    cyc();
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b1;
    inst_rdata   = 32'h5555_0020;
    stall_id     = 1'b1;
    cyc();
    inst_data_ok = 1'b0;
    flush        = 1'b1;
    cyc();
    flush    = 1'b0;
    stall_id = 1'b0;
    check("done_flush", {ic_to_id_bus[64], ic_to_id_bus[31:0]}, 33'h0);
    exp_q.delete();

    // 6a: reset during WAIT
    exp_addr_q.push_back(32'hBFC0_0040);
    start_pc(32'hBFC0_0040, 32'h0);
    inst_addr_ok = 1'b1;
    cyc();
    inst_addr_ok = 1'b0;
    resetn = 1'b0;
    cyc();
    check("rst_wait_bus", ic_to_id_bus, 97'h0);
    check("rst_wait_req", {65'h0, inst_req, inst_addr}, 97'h0);
    check("rst_wait_stall", {94'h0, stallreq_ic, dbg_state[1:0]}, 97'h0);
    resetn = 1'b1;
    cyc();

    // 6b: flush coincident with addr_ok -> CANCEL absorbs data_ok
    exp_addr_q.push_back(32'hBFC0_0050);
    start_pc(32'hBFC0_0050, 32'h0);
    inst_addr_ok = 1'b1;
    flush        = 1'b1;
    cyc();
    inst_addr_ok = 1'b0;
    flush        = 1'b0;
    check("req_flush_ok_cancel", {inst_req, stallreq_ic, dbg_state}, {1'b0, 1'b1, ST_CANCEL});
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    check("cancel_ignores_flush", 97'(dbg_state), 97'(ST_CANCEL));
    inst_data_ok = 1'b1;
    inst_rdata   = 32'hDEAD_BEEF;
    cyc();
    inst_data_ok = 1'b0;
    check("cancel_absorb", {stallreq_ic, dbg_state}, {1'b0, ST_IDLE});
    fetch(32'hBFC0_0054, 32'h0, 1, 1, 32'h6666_0054, 0);

    repeat (4) cyc();
    check("exp_q_drained", 97'(exp_q.size()), 97'd0);
    check("addr_q_drained", 97'(exp_addr_q.size()), 97'd0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
